// File: rtl/riscv_pkg.sv
// Shared RV32I execute/writeback definitions: data width, ALU type and funct3 encodings,
// and pipeline register payloads.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned SHW    = 5;

  typedef enum logic [1:0] {
    ALU_R     = 2'b00,
    ALU_I     = 2'b01,
    ALU_ADD   = 2'b10,
    ALU_PASSB = 2'b11
  } alu_type_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_NT2  = 3'b010,
    BR_NT3  = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } br_f3_e;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   pc4;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memwrite;
    logic              wb_sel;
    logic              jump;
  } exmem_t;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [REG_AW-1:0] rd;
    logic              we;
  } memwb_t;

endpackage

// File: rtl/alu.sv
// RV32I integer ALU: R/I-type funct3 operations, plain add, and pass-through of operand B.
module alu #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      alu_type,
  input  logic [2:0]      funct3,
  input  logic            alt,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // alt selects sub (R-type only) and arithmetic right shift
  always_comb begin
    result = '0;
    case (alu_type_e'(alu_type))
      ALU_ADD:   result = a + b;
      ALU_PASSB: result = b;
      default: begin
        case (alu_f3_e'(funct3))
          F3_ADD:  result = (alu_type == ALU_R && alt) ? (a - b) : (a + b);
          F3_SLL:  result = a << shamt;
          F3_SLT:  result = XLEN'($signed(a) < $signed(b));
          F3_SLTU: result = XLEN'(a < b);
          F3_XOR:  result = a ^ b;
          F3_SR:   result = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
          F3_OR:   result = a | b;
          F3_AND:  result = a & b;
          default: result = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/execute_writeback.sv
// Execute, memory and writeback stages of a 5-stage RV32I pipeline: ALU, branch resolution,
// EX/MEM and MEM/WB registers, data-memory port and register-file write port.
module execute_writeback #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ID_EX_A,
  input  logic [XLEN-1:0] ID_EX_B,
  input  logic [XLEN-1:0] ID_EX_IMM,
  input  logic [XLEN-1:0] ID_EX_PC,
  input  logic [4:0]      ID_EX_RD,
  input  logic [2:0]      alucontrol,
  input  logic [6:0]      alucontrol7,
  input  logic [1:0]      alu_type_sel,
  input  logic            b_imm_sel,
  input  logic            branch,
  input  logic            jump,
  input  logic            memwrite_en,
  input  logic            regwrite_en,
  input  logic            wb_sel,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCtarget,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] WB_ID_WD3,
  output logic [4:0]      WB_ID_RD_A3,
  output logic            WB_ID_WE3
);
  import riscv_pkg::*;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] wb_data_c;
  logic            br_cond;
  logic            unused_f7;
  exmem_t          exm;
  memwb_t          mwb;

  assign op_b      = b_imm_sel ? ID_EX_IMM : ID_EX_B;
  assign unused_f7 = ^{alucontrol7[6], alucontrol7[4:0]};

  alu #(.XLEN(XLEN)) u_alu (
    .a        (ID_EX_A),
    .b        (op_b),
    .alu_type (alu_type_sel),
    .funct3   (alucontrol),
    .alt      (alucontrol7[5]),
    .result   (alu_result)
  );

  // branch compare always uses the register operands, never the immediate
  always_comb begin
    br_cond = 1'b0;
    case (br_f3_e'(alucontrol))
      BR_EQ:   br_cond = (ID_EX_A == ID_EX_B);
      BR_NE:   br_cond = (ID_EX_A != ID_EX_B);
      BR_LT:   br_cond = ($signed(ID_EX_A) <  $signed(ID_EX_B));
      BR_GE:   br_cond = ($signed(ID_EX_A) >= $signed(ID_EX_B));
      BR_LTU:  br_cond = (ID_EX_A <  ID_EX_B);
      BR_GEU:  br_cond = (ID_EX_A >= ID_EX_B);
      default: br_cond = 1'b0;
    endcase
  end

  assign PCSrcE   = jump | (branch & br_cond);
  assign PCtarget = ID_EX_PC + ID_EX_IMM;

  // EX/MEM register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exm <= '0;
    end else begin
      exm.result   <= alu_result;
      exm.b        <= ID_EX_B;
      exm.pc4      <= ID_EX_PC + XLEN'(4);
      exm.rd       <= ID_EX_RD;
      exm.regwrite <= regwrite_en;
      exm.memwrite <= memwrite_en;
      exm.wb_sel   <= wb_sel;
      exm.jump     <= jump;
    end
  end

  assign dmem_addr  = exm.result;
  assign dmem_wdata = exm.b;
  assign dmem_we    = exm.memwrite;

  assign wb_data_c = exm.jump ? exm.pc4 : (exm.wb_sel ? dmem_rdata : exm.result);

  // MEM/WB register; writes to x0 are suppressed here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mwb <= '0;
    end else begin
      mwb.data <= wb_data_c;
      mwb.rd   <= exm.rd;
      mwb.we   <= exm.regwrite && (exm.rd != '0);
    end
  end

  assign WB_ID_WD3   = mwb.data;
  assign WB_ID_RD_A3 = mwb.rd;
  assign WB_ID_WE3   = mwb.we;

endmodule

// File: tb/tb_execute_writeback.sv
// Directed bench for execute_writeback: ALU ops, branches, jumps, store/load and reset behaviour.
module tb_execute_writeback;

  logic        clk;
  logic        rst;
  logic [31:0] ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_PC;
  logic [4:0]  ID_EX_RD;
  logic [2:0]  alucontrol;
  logic [6:0]  alucontrol7;
  logic [1:0]  alu_type_sel;
  logic        b_imm_sel, branch, jump, memwrite_en, regwrite_en, wb_sel;
  logic        PCSrcE;
  logic [31:0] PCtarget, dmem_addr, dmem_wdata, dmem_rdata, WB_ID_WD3;
  logic        dmem_we;
  logic [4:0]  WB_ID_RD_A3;
  logic        WB_ID_WE3;

  int checks = 0;
  int errors = 0;

  execute_writeback #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_EX_A      (ID_EX_A),
    .ID_EX_B      (ID_EX_B),
    .ID_EX_IMM    (ID_EX_IMM),
    .ID_EX_PC     (ID_EX_PC),
    .ID_EX_RD     (ID_EX_RD),
    .alucontrol   (alucontrol),
    .alucontrol7  (alucontrol7),
    .alu_type_sel (alu_type_sel),
    .b_imm_sel    (b_imm_sel),
    .branch       (branch),
    .jump         (jump),
    .memwrite_en  (memwrite_en),
    .regwrite_en  (regwrite_en),
    .wb_sel       (wb_sel),
    .PCSrcE       (PCSrcE),
    .PCtarget     (PCtarget),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .WB_ID_WD3    (WB_ID_WD3),
    .WB_ID_RD_A3  (WB_ID_RD_A3),
    .WB_ID_WE3    (WB_ID_WE3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    ID_EX_A = '0; ID_EX_B = '0; ID_EX_IMM = '0; ID_EX_PC = '0; ID_EX_RD = '0;
    alucontrol = '0; alucontrol7 = '0; alu_type_sel = '0;
    b_imm_sel = 1'b0; branch = 1'b0; jump = 1'b0;
    memwrite_en = 1'b0; regwrite_en = 1'b0; wb_sel = 1'b0;
  endtask

  // issue one ALU instruction, then nops; check writeback two cycles later
  task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic bsel, input logic [1:0] typ,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                        input logic [31:0] exp);
    nop();
    ID_EX_A = a; ID_EX_B = b; ID_EX_IMM = imm; b_imm_sel = bsel;
    alu_type_sel = typ; alucontrol = f3; alucontrol7 = f7;
    ID_EX_RD = rd; regwrite_en = 1'b1;
    tick();
    nop();
    tick();
    check(tag, WB_ID_WD3, exp);
    check({tag, "_rd"}, 32'(WB_ID_RD_A3), 32'(rd));
    check({tag, "_we"}, 32'(WB_ID_WE3), 32'(rd != 5'd0));
  endtask

  initial begin
    rst = 1'b0;
    dmem_rdata = '0;
    nop();
    #12;
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_we3", 32'(WB_ID_WE3), 32'd0);
    check("rst_wd3", WB_ID_WD3, 32'd0);
    check("rst_rd", 32'(WB_ID_RD_A3), 32'd0);
    ID_EX_PC = 32'h10; ID_EX_IMM = 32'h4; jump = 1'b1;
    #1;
    check("rst_pcsrc", 32'(PCSrcE), 32'd1);
    check("rst_pctarget", PCtarget, 32'h14);
    nop();
    tick();
    rst = 1'b1;
    tick();

    alu_op("r_add", 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 3'b000, 7'h00, 5'd3, 32'd12);
    alu_op("r_sub", 32'h80000000, 32'd4, 32'd0, 1'b0, 2'b00, 3'b000, 7'h20, 5'd5, 32'h7FFFFFFC);
    alu_op("r_sra", 32'h80000000, 32'd4, 32'd0, 1'b0, 2'b00, 3'b101, 7'h20, 5'd6, 32'hF8000000);
    alu_op("r_srl", 32'h80000000, 32'd4, 32'd0, 1'b0, 2'b00, 3'b101, 7'h00, 5'd6, 32'h08000000);
    alu_op("r_sll", 32'h00000003, 32'd33, 32'd0, 1'b0, 2'b00, 3'b001, 7'h00, 5'd8, 32'h00000006);
    alu_op("r_slt", 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'b00, 3'b010, 7'h00, 5'd9, 32'd1);
    alu_op("r_sltu", 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'b00, 3'b011, 7'h00, 5'd9, 32'd0);
    alu_op("r_xor", 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 2'b00, 3'b100, 7'h00, 5'd10, 32'h0FF00FF0);
    alu_op("r_or", 32'hF0F0F0F0, 32'h0000FFFF, 32'd0, 1'b0, 2'b00, 3'b110, 7'h00, 5'd11, 32'hF0F0FFFF);
    alu_op("r_and", 32'hF0F0F0F0, 32'h0000FFFF, 32'd0, 1'b0, 2'b00, 3'b111, 7'h00, 5'd12, 32'h0000F0F0);
    alu_op("i_add_f7", 32'd10, 32'd99, 32'hFFFFFFFD, 1'b1, 2'b01, 3'b000, 7'h7F, 5'd13, 32'd7);
    alu_op("add_wrap", 32'hFFFFFFFF, 32'd0, 32'd2, 1'b1, 2'b10, 3'b111, 7'h20, 5'd14, 32'd1);
    alu_op("lui", 32'h11111111, 32'd0, 32'h12345000, 1'b1, 2'b11, 3'b000, 7'h00, 5'd2, 32'h12345000);
    alu_op("rd0", 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 3'b000, 7'h00, 5'd0, 32'd12);

    nop();
    ID_EX_A = 32'hFFFFFFFF; ID_EX_B = 32'd1; branch = 1'b1; alucontrol = 3'b100;
    ID_EX_PC = 32'h100; ID_EX_IMM = 32'h20;
    #1;
    check("blt_pcsrc", 32'(PCSrcE), 32'd1);
    check("blt_target", PCtarget, 32'h120);
    alucontrol = 3'b110;
    #1;
    check("bltu_pcsrc", 32'(PCSrcE), 32'd0);
    alucontrol = 3'b111;
    #1;
    check("bgeu_pcsrc", 32'(PCSrcE), 32'd1);
    alucontrol = 3'b011;
    #1;
    check("br011_pcsrc", 32'(PCSrcE), 32'd0);
    ID_EX_B = 32'hFFFFFFFF; alucontrol = 3'b000;
    #1;
    check("beq_pcsrc", 32'(PCSrcE), 32'd1);
    branch = 1'b0;
    #1;
    check("nobranch_pcsrc", 32'(PCSrcE), 32'd0);

    nop();
    ID_EX_A = 32'h40; ID_EX_IMM = 32'h4; ID_EX_B = 32'hDEADBEEF;
    b_imm_sel = 1'b1; alu_type_sel = 2'b10; memwrite_en = 1'b1;
    tick();
    nop();
    check("sw_we", 32'(dmem_we), 32'd1);
    check("sw_addr", dmem_addr, 32'h44);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    tick();
    check("sw_we_drop", 32'(dmem_we), 32'd0);
    check("sw_no_wb", 32'(WB_ID_WE3), 32'd0);

    ID_EX_A = 32'h40; ID_EX_IMM = 32'h4; b_imm_sel = 1'b1; alu_type_sel = 2'b10;
    wb_sel = 1'b1; regwrite_en = 1'b1; ID_EX_RD = 5'd7;
    tick();
    nop();
    dmem_rdata = 32'hDEADBEEF;
    check("lw_addr", dmem_addr, 32'h44);
    check("lw_we", 32'(dmem_we), 32'd0);
    tick();
    dmem_rdata = '0;
    check("lw_wd3", WB_ID_WD3, 32'hDEADBEEF);
    check("lw_rd", 32'(WB_ID_RD_A3), 32'd7);
    check("lw_we3", 32'(WB_ID_WE3), 32'd1);

    ID_EX_PC = 32'h200; ID_EX_IMM = 32'h10; jump = 1'b1; regwrite_en = 1'b1; ID_EX_RD = 5'd1;
    #1;
    check("jal_pcsrc", 32'(PCSrcE), 32'd1);
    check("jal_target", PCtarget, 32'h210);
    tick();
    nop();
    tick();
    check("jal_wd3", WB_ID_WD3, 32'h204);
    check("jal_rd", 32'(WB_ID_RD_A3), 32'd1);
    check("jal_we3", 32'(WB_ID_WE3), 32'd1);
    ID_EX_PC = 32'h200; ID_EX_IMM = 32'h10; jump = 1'b1; regwrite_en = 1'b1; ID_EX_RD = 5'd0;
    tick();
    nop();
    tick();
    check("jal0_wd3", WB_ID_WD3, 32'h204);
    check("jal0_we3", 32'(WB_ID_WE3), 32'd0);

    // branch and store in flight together: redirect and store both proceed
    ID_EX_A = 32'h80; ID_EX_B = 32'h80; ID_EX_IMM = 32'h8; ID_EX_PC = 32'h300;
    b_imm_sel = 1'b1; alu_type_sel = 2'b10; memwrite_en = 1'b1; branch = 1'b1;
    #1;
    check("brst_pcsrc", 32'(PCSrcE), 32'd1);
    check("brst_target", PCtarget, 32'h308);
    tick();
    nop();
    check("brst_we", 32'(dmem_we), 32'd1);
    check("brst_addr", dmem_addr, 32'h88);
    tick();

    // reset during the memory cycle of a store, with an older write in WB
    ID_EX_A = 32'd1; ID_EX_B = 32'd2; regwrite_en = 1'b1; ID_EX_RD = 5'd4;
    tick();
    nop();
    ID_EX_A = 32'h40; ID_EX_IMM = 32'h8; ID_EX_B = 32'h55;
    b_imm_sel = 1'b1; alu_type_sel = 2'b10; memwrite_en = 1'b1;
    tick();
    nop();
    check("mid_dmem_we", 32'(dmem_we), 32'd1);
    check("mid_we3", 32'(WB_ID_WE3), 32'd1);
    check("mid_wd3", WB_ID_WD3, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_dmem_we", 32'(dmem_we), 32'd0);
    check("rstmid_we3", 32'(WB_ID_WE3), 32'd0);
    check("rstmid_wd3", WB_ID_WD3, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post_dmem_we", 32'(dmem_we), 32'd0);
    tick();
    check("post_dmem_we2", 32'(dmem_we), 32'd0);
    check("post_we3", 32'(WB_ID_WE3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
